// File: rtl/alu_pkg.sv
// Shared constants and small helpers for the ALU and its sharing arbiter.
package alu_pkg;

  // ALU op codes. LUI and SLL ignore bit 0 of the op code.
  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;

  // Requester port indices.
  localparam logic PORT_EXE = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Signed overflow of s = a + b.
  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  // Signed overflow of s = a - b.
  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] s);
    return (a[31] != b[31]) && (s[31] != a[31]);
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit MIPS-style ALU. Shifts move operand b by a[4:0].
// carry: carry-out for ADDU/ADD, borrow for SUBU/SUB/SLTU, 0 otherwise.
// overflow: signed overflow for ADD/SUB only.
module alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  aluc_i,
  output logic [31:0] r_o,
  output logic        zero_o,
  output logic        carry_o,
  output logic        negative_o,
  output logic        overflow_o
);
  import alu_pkg::*;

  logic [32:0] ext_s;

  // Decode the op code and compute result plus carry/overflow.
  always_comb begin
    ext_s      = 33'd0;
    r_o        = 32'd0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (aluc_i)
      ALU_ADDU, ALU_ADD: begin
        ext_s   = {1'b0, a_i} + {1'b0, b_i};
        r_o     = ext_s[31:0];
        carry_o = ext_s[32];
        if (aluc_i == ALU_ADD) overflow_o = add_ovf(a_i, b_i, ext_s[31:0]);
        else                   overflow_o = 1'b0;
      end
      ALU_SUBU, ALU_SUB: begin
        ext_s   = {1'b0, a_i} - {1'b0, b_i};
        r_o     = ext_s[31:0];
        carry_o = ext_s[32];
        if (aluc_i == ALU_SUB) overflow_o = sub_ovf(a_i, b_i, ext_s[31:0]);
        else                   overflow_o = 1'b0;
      end
      ALU_AND: r_o = a_i & b_i;
      ALU_OR:  r_o = a_i | b_i;
      ALU_XOR: r_o = a_i ^ b_i;
      ALU_NOR: r_o = ~(a_i | b_i);
      ALU_LUI, (ALU_LUI | 4'b0001): r_o = {b_i[15:0], 16'h0000};
      ALU_SLTU: begin
        r_o     = {31'd0, (a_i < b_i)};
        carry_o = (a_i < b_i);
      end
      ALU_SLT: r_o = {31'd0, ($signed(a_i) < $signed(b_i))};
      ALU_SRA: r_o = $signed(b_i) >>> a_i[4:0];
      ALU_SRL: r_o = b_i >> a_i[4:0];
      ALU_SLL, (ALU_SLL | 4'b0001): r_o = b_i << a_i[4:0];
      default: r_o = 32'd0;
    endcase
  end

  assign zero_o     = (r_o == 32'd0);
  assign negative_o = r_o[31];

endmodule

// File: rtl/alu_rr_pick.sv
// Two-way grant with a round-robin pointer. The pointer names the port that
// wins when both are valid; it moves to the other port after each accept.
// With FIXED_PRIO != 0, port 0 always wins a tie.
module alu_rr_pick #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       adv_i,
  output logic [1:0] grant_o
);
  logic ptr_q;
  logic ptr_d;
  logic prio_s;

  assign prio_s = (FIXED_PRIO != 0) ? 1'b0 : ptr_q;

  // Grant from request valids and the priority port only.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = prio_s ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // After an accept, hand priority to the port that did not win.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && (FIXED_PRIO == 0)) ptr_d = ~grant_o[1];
    else                            ptr_d = ptr_q;
  end

  // Pointer register, back to port 0 on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the execute stage (port 0) and the branch/address
// unit (port 1). One op per cycle is accepted into a single-entry registered
// response slot; the slot may be drained and refilled in the same cycle.
module alu_share_arbiter #(
  parameter int ID_W       = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [31:0]     req0_a,
  input  logic [31:0]     req0_b,
  input  logic [3:0]      req0_aluc,
  input  logic [ID_W-1:0] req0_id,
  input  logic [31:0]     req1_a,
  input  logic [31:0]     req1_b,
  input  logic [3:0]      req1_aluc,
  input  logic [ID_W-1:0] req1_id,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_src,
  output logic [ID_W-1:0] rsp_id,
  output logic [31:0]     rsp_r,
  output logic            rsp_zero,
  output logic            rsp_carry,
  output logic            rsp_negative,
  output logic            rsp_overflow
);
  import alu_pkg::*;

  logic [1:0]      grant_s;
  logic            free_s;
  logic            accept_s;
  logic            sel_s;
  logic [31:0]     op_a_s;
  logic [31:0]     op_b_s;
  logic [3:0]      op_c_s;
  logic [ID_W-1:0] op_id_s;
  logic [31:0]     alu_r_s;
  logic [3:0]      alu_flags_s;

  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_src_q,   rsp_src_d;
  logic [ID_W-1:0] rsp_id_q,    rsp_id_d;
  logic [31:0]     rsp_r_q,     rsp_r_d;
  logic [3:0]      rsp_flags_q, rsp_flags_d;  // {zero, carry, negative, overflow}

  alu_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (req_valid),
    .adv_i   (accept_s),
    .grant_o (grant_s)
  );

  // The slot can take a new op when empty or being drained this cycle.
  assign free_s    = !rsp_valid_q || rsp_ready;
  assign req_ready = (rst_n && free_s) ? grant_s : 2'b00;
  assign accept_s  = |(req_valid & req_ready);

  // Operand mux follows the grant; the ALU runs in the accept cycle.
  assign sel_s   = grant_s[PORT_AUX];
  assign op_a_s  = sel_s ? req1_a    : req0_a;
  assign op_b_s  = sel_s ? req1_b    : req0_b;
  assign op_c_s  = sel_s ? req1_aluc : req0_aluc;
  assign op_id_s = sel_s ? req1_id   : req0_id;

  alu u_alu (
    .a_i        (op_a_s),
    .b_i        (op_b_s),
    .aluc_i     (op_c_s),
    .r_o        (alu_r_s),
    .zero_o     (alu_flags_s[3]),
    .carry_o    (alu_flags_s[2]),
    .negative_o (alu_flags_s[1]),
    .overflow_o (alu_flags_s[0])
  );

  // Response slot: load on accept, clear valid on a plain drain, else hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_src_d   = rsp_src_q;
    rsp_id_d    = rsp_id_q;
    rsp_r_d     = rsp_r_q;
    rsp_flags_d = rsp_flags_q;
    if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_src_d   = sel_s;
      rsp_id_d    = op_id_s;
      rsp_r_d     = alu_r_s;
      rsp_flags_d = alu_flags_s;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Response registers; reset discards any pending response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_src_q   <= 1'b0;
      rsp_id_q    <= {ID_W{1'b0}};
      rsp_r_q     <= 32'd0;
      rsp_flags_q <= 4'd0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_src_q   <= rsp_src_d;
      rsp_id_q    <= rsp_id_d;
      rsp_r_q     <= rsp_r_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_src      = rsp_src_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_r        = rsp_r_q;
  assign rsp_zero     = rsp_flags_q[3];
  assign rsp_carry    = rsp_flags_q[2];
  assign rsp_negative = rsp_flags_q[1];
  assign rsp_overflow = rsp_flags_q[0];

endmodule
